// File: rtl/relu_stream_pkg.sv
// Shared types and constants for the ReLU streaming sequencer.
package relu_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] ZERO_WORD  = 32'h0;

  // Sign bit set covers negatives, -0.0 and negative NaNs alike.
  function automatic logic [31:0] relu(input logic [31:0] w);
    return w[31] ? ZERO_WORD : w;
  endfunction

endpackage

// File: rtl/relu_stream_fifo.sv
// Synchronous result buffer between the ReLU register and the write port.
module relu_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/relu_stream_ctrl.sv
// Streams a vector of fp32 words memory -> ReLU register -> FIFO -> memory,
// with read issue throttled by credits so the FIFO can never overflow.
module relu_stream_ctrl
  import relu_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_req_o,
  output logic [31:0]      rd_addr_o,
  input  logic             rd_gnt_i,
  input  logic             rd_rvalid_i,
  input  logic [31:0]      rd_rdata_i,
  output logic             wr_req_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_wdata_o,
  input  logic             wr_gnt_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_e           state, state_nxt;
  logic [LEN_W-1:0] len_q, issued, wr_cnt;
  logic [31:0]      rd_addr_q, wr_addr_q, stage_data, fifo_head;
  logic             stage_vld, fifo_full, fifo_empty;
  logic [CW-1:0]    outstanding, fifo_count;
  logic [CW:0]      occupancy;
  logic             accept, rd_hs, rsp_ok, wr_hs, last_wr;

  // Every slot a read could eventually land in counts against the credit pool.
  assign occupancy = (CW+1)'(outstanding) + (CW+1)'(fifo_count) + (CW+1)'(stage_vld);

  assign accept   = (state == IDLE) && start_i;
  assign rd_req_o = (state == RUN) && (issued != len_q) && (occupancy < DEPTH_C);
  assign rd_hs    = rd_req_o && rd_gnt_i;
  assign rsp_ok   = rd_rvalid_i && (outstanding != '0);
  assign wr_req_o = !fifo_empty;
  assign wr_hs    = wr_req_o && wr_gnt_i;
  assign last_wr  = wr_hs && ((wr_cnt + LEN_W'(1)) == len_q);

  assign busy_o     = (state == RUN);
  assign done_o     = (state == DONE);
  assign rd_addr_o  = rd_addr_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_wdata_o = fifo_empty ? ZERO_WORD : fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = (len_i == '0) ? DONE : RUN;
      RUN:     if (last_wr) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      issued      <= '0;
      wr_cnt      <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      outstanding <= '0;
      stage_vld   <= 1'b0;
      stage_data  <= '0;
    end else begin
      if (accept) begin
        len_q     <= len_i;
        rd_addr_q <= src_addr_i;
        wr_addr_q <= dst_addr_i;
        issued    <= '0;
        wr_cnt    <= '0;
      end else begin
        if (rd_hs) begin
          rd_addr_q <= rd_addr_q + WORD_BYTES;
          issued    <= issued + LEN_W'(1);
        end
        if (wr_hs) begin
          wr_addr_q <= wr_addr_q + WORD_BYTES;
          wr_cnt    <= wr_cnt + LEN_W'(1);
        end
      end
      outstanding <= outstanding + CW'(rd_hs) - CW'(rsp_ok);
      stage_vld   <= rsp_ok;
      if (rsp_ok) stage_data <= relu(rd_rdata_i);
    end
  end

  relu_stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage_vld),
    .din   (stage_data),
    .pop   (wr_hs),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A response with nothing outstanding is a system error; its data is dropped.
  a_rvalid_legal: assert property (@(posedge clk) disable iff (!rst_n)
    rd_rvalid_i |-> (outstanding != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    stage_vld |-> !fifo_full);

endmodule
